// File: rtl/rr_grant_arbiter.sv
// -----------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter sharing one decoded resource among N requesters.
// The winner index is registered and decoded (with enable) into a one-hot
// grant. A hold timer bounds tenure so no requester can starve the others,
// and every release passes through at least one IDLE cycle so the downstream
// decoder always sees a gnt=0 gap between owners.
//
// Ports
//   clk      in   1     rising-edge clock
//   rst      in   1     synchronous, active-high reset
//   en       in   1     arbiter/decoder enable; 0 = no grant issued
//   req      in   N     level-sensitive request vector, bit i = requester i
//   done     in   1     current owner releases the resource this cycle
//   gnt      out  N     one-hot grant, all-zero when idle or disabled
//   gnt_idx  out  IDXW  index of current owner, meaningful only when busy=1
//   busy     out  1     high while a grant is held
//   timeout  out  1     one-cycle pulse after a grant is revoked by the timer
// -----------------------------------------------------------------------------
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            busy,
    output logic            timeout
);

    // Hold counter only needs to reach MAX_HOLD-1; keep one bit when disabled.
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] win_idx;
    logic            win_vld;

    // Rotating priority scan: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    always_comb begin
        int              j;
        logic [IDXW-1:0] jj;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDXW'(j);
            if (!win_vld && req[jj]) begin
                win_vld = 1'b1;
                win_idx = jj;
            end
        end
    end

    always_comb begin
        logic rel;
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        rel       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && win_vld) begin
                    state_d = S_GRANT;
                    idx_d   = win_idx;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                // Priority order: disable, voluntary release/drop, timer.
                // A done coinciding with the limit is a normal release.
                if (!en || done || !req[idx_q]) begin
                    rel = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
                if (rel) begin
                    state_d = S_IDLE;
                    ptr_d   = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = (state_q == S_GRANT);
    assign gnt_idx = idx_q;
    assign timeout = timeout_q;
    assign gnt     = busy ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Directed scenarios followed by randomized req/en/done traffic. A behavioural
// reference model (owner as an integer, rotating candidate list) predicts the
// grant, busy, gnt_idx and timeout after every clock edge.
// -----------------------------------------------------------------------------
module tb_rr_grant_arbiter;

    localparam int N        = 4;
    localparam int IDXW     = 2;
    localparam int MAX_HOLD = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            busy;
    logic            timeout;

    rr_grant_arbiter #(
        .N        (N),
        .IDXW     (IDXW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: owner = -1 means nobody holds the resource.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    logic m_to    = 1'b0;

    // Grants given to others while requester i kept asking.
    int   wait_cnt [N];
    logic prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int  order [$];
        int  w;
        logic rel;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (en && req != '0) begin
                for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
                w = -1;
                foreach (order[q]) if (w < 0 && req[order[q]]) w = order[q];
                m_owner = w;
                m_held  = 1;
            end
        end else begin
            m_to = 1'b0;
            rel  = 1'b0;
            if (!en || done || !req[m_owner]) rel = 1'b1;
            else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end else m_held++;
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] r_at;
        logic         rst_at;
        int           w;
        r_at   = req;
        rst_at = rst;
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (rst_at) begin
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (busy && !prev_busy) begin
            w = int'(gnt_idx);
            for (int i = 0; i < N; i++) begin
                if (i == w) wait_cnt[i] = 0;
                else if (r_at[i]) begin
                    wait_cnt[i]++;
                    chk("starve", 32'(wait_cnt[i] < N), 32'd1);
                end else wait_cnt[i] = 0;
            end
        end
        prev_busy = busy;
    endtask

    initial begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        rst  = 1'b1;
        en   = 1'b1;
        req  = 4'b1111;
        done = 1'b0;

        // Reset held for two clocks with all requests active.
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;

        // Full rotation with done after two cycles of tenure.
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_order", 32'(gnt), 32'd1 << (g % N));
            step();
            done = 1'b1;
            step();
            chk("rr_gap", 32'(gnt), 32'd0);
            done = 1'b0;
        end

        // Single requester, no done: timer revokes after MAX_HOLD cycles.
        req = 4'b1000;
        step();
        chk("hold_first", 32'(gnt), 32'b1000);
        for (int c = 1; c < MAX_HOLD; c++) begin
            step();
            chk("hold_run", 32'(gnt), 32'b1000);
        end
        step();
        chk("to_gnt", 32'(gnt), 32'd0);
        chk("to_pulse", 32'(timeout), 32'd1);
        step();
        chk("to_regrant", 32'(gnt), 32'b1000);
        chk("to_clear", 32'(timeout), 32'd0);

        // Owner idx2 then en drops; afterwards ptr=3 wraps to idx0.
        req = 4'b0100;
        step();
        step();
        chk("own2", 32'(gnt), 32'b0100);
        en = 1'b0;
        step();
        chk("en_off_gnt", 32'(gnt), 32'd0);
        chk("en_off_busy", 32'(busy), 32'd0);
        en  = 1'b1;
        req = 4'b0101;
        step();
        chk("wrap_idx0", 32'(gnt), 32'b0001);

        // Reset in the middle of a grant at idx1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0010;
        step();
        chk("own1", 32'(gnt), 32'b0010);
        rst = 1'b1;
        step();
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req = 4'b0011;
        step();
        chk("post_rst_idx0", 32'(gnt), 32'b0001);

        // done on the same edge as the hold limit: plain release.
        req = 4'b0001;
        for (int c = 1; c < MAX_HOLD; c++) step();
        done = 1'b1;
        step();
        chk("done_lim_gnt", 32'(gnt), 32'd0);
        chk("done_lim_to", 32'(timeout), 32'd0);
        done = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 10000; c++) begin
            rst  = ($urandom_range(0, 1999) == 0);
            en   = ($urandom_range(0, 15) != 0);
            req  = N'($urandom);
            done = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
